// File: rtl/occupancy_monitor.sv
// occupancy_monitor: saturating occupancy counter with registered level flags and overflow/underflow alarm
// Ports:
//    clk          rising-edge clock
//    reset        synchronous active-high reset
//    up_count     one arrival this cycle
//    down_count   one departure this cycle
//    alarm_clr    clears alarm_cause (only when OCC_ALARM_LATCH_EN is defined)
//    count        current occupancy
//    empty_flag   count == 0
//    full_flag    count == CAP
//    almost_empty count <= AE_LVL
//    almost_full  count >= AF_LVL
//    alarm        OR of alarm_cause bits
//    alarm_cause  bit1 overflow, bit0 underflow
//    err_cnt      saturating count of overflow/underflow events
// Macro OCC_ALARM_LATCH_EN: defined -> alarm_cause sticky until alarm_clr/reset;
// undefined -> alarm_cause is a one-cycle pulse per event and alarm_clr is ignored.
module occupancy_monitor #(
   parameter int CNT_W  = 3,
   parameter int CAP    = 7,
   parameter int AF_LVL = 6,
   parameter int AE_LVL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_count,
   input  logic             down_count,
   input  logic             alarm_clr,
   output logic [CNT_W-1:0] count,
   output logic             empty_flag,
   output logic             full_flag,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             alarm,
   output logic [1:0]       alarm_cause,
   output logic [7:0]       err_cnt
);
   typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} occ_e;
   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
   localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_LVL);
   localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_LVL);
   occ_e             st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       err_q, err_d;
   logic             empty_q, full_q, ae_q, af_q, alarm_q;
   logic             up_only, dn_only, ovf, unf;
`ifndef OCC_ALARM_LATCH_EN
   logic             unused_clr;
   assign unused_clr = alarm_clr;
`endif
   always_comb begin
      up_only = up_count & ~down_count;
      dn_only = down_count & ~up_count;
      // state tracks cnt_q, so FULL/EMPTY decide saturation without a compare
      ovf     = up_only & (st_q == S_FULL);
      unf     = dn_only & (st_q == S_EMPTY);
      cnt_d   = (up_only & ~ovf) ? cnt_q + CNT_W'(1) : (dn_only & ~unf) ? cnt_q - CNT_W'(1) : cnt_q;
      st_d    = (cnt_d == '0) ? S_EMPTY : (cnt_d == CAP_C) ? S_FULL : S_PARTIAL;
`ifdef OCC_ALARM_LATCH_EN
      // a coincident clear drops old causes but keeps this cycle's event
      cause_d = alarm_clr ? {ovf, unf} : (cause_q | {ovf, unf});
`else
      cause_d = {ovf, unf};
`endif
      err_d   = ((ovf | unf) && err_q != 8'hff) ? err_q + 8'd1 : err_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= S_EMPTY;
         cnt_q   <= '0;
         cause_q <= '0;
         err_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ae_q    <= 1'b1;
         af_q    <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         err_q   <= err_d;
         empty_q <= st_d == S_EMPTY;
         full_q  <= st_d == S_FULL;
         ae_q    <= cnt_d <= AE_C;
         af_q    <= cnt_d >= AF_C;
         alarm_q <= |cause_d;
      end
   end
   assign count        = cnt_q;
   assign empty_flag   = empty_q;
   assign full_flag    = full_q;
   assign almost_empty = ae_q;
   assign almost_full  = af_q;
   assign alarm        = alarm_q;
   assign alarm_cause  = cause_q;
   assign err_cnt      = err_q;
endmodule

// File: doc/occupancy_monitor.md
OCCUPANCY_MONITOR -- requirements
Module: occupancy_monitor

Interface
REQ-001 Parameter CNT_W, default 3: width of the occupancy count.
REQ-002 Parameter CAP, default 7: maximum occupancy, 1 <= CAP <= 2^CNT_W-1.
REQ-003 Parameter AF_LVL, default 6: almost-full threshold, 0 < AF_LVL <= CAP.
REQ-004 Parameter AE_LVL, default 1: almost-empty threshold, 0 <= AE_LVL < CAP.
REQ-005 clk  input  1  the only clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 up_count  input  1  one arrival this cycle.
REQ-008 down_count  input  1  one departure this cycle.
REQ-009 alarm_clr  input  1  clears the latched alarm and error cause.
REQ-010 count  output  CNT_W  current occupancy.
REQ-011 empty_flag, full_flag  output  1 each  count==0 and count==CAP.
REQ-012 almost_empty, almost_full  output  1 each  count<=AE_LVL and count>=AF_LVL.
REQ-013 alarm  output  1  overflow/underflow indication.
REQ-014 alarm_cause  output  2  bit1 overflow, bit0 underflow.
REQ-015 err_cnt  output  8  saturating count of overflow+underflow events.

Function
REQ-016 Every output SHALL be a register; no combinational input-to-output path.
REQ-017 up_count only, count<CAP: count increments by 1 at the next edge.
REQ-018 down_count only, count>0: count decrements by 1 at the next edge.
REQ-019 up_count and down_count together: count unchanged, no alarm, at any occupancy including 0 and CAP.
REQ-020 up_count only at count==CAP: overflow event; count holds at CAP (no wrap).
REQ-021 down_count only at count==0: underflow event; count holds at 0 (no wrap).
REQ-022 Flags SHALL be computed from the next count value, so flags and count agree in the same cycle (1-cycle latency from event).
REQ-023 Occupancy state machine: EMPTY (count==0), PARTIAL (0<count<CAP), FULL (count==CAP); transitions EMPTY<->PARTIAL, PARTIAL<->FULL only by single steps; EMPTY<->FULL direct only when CAP==1.
REQ-024 Each overflow/underflow event sets the corresponding alarm_cause bit at the next edge and increments err_cnt by 1, saturating at 255.
REQ-025 alarm SHALL equal the OR of alarm_cause bits.
REQ-026 alarm_clr clears alarm_cause at the next edge; err_cnt is not cleared.
REQ-027 alarm_clr coincident with a new event: the new event's cause bit wins (set), other bit cleared.
REQ-028 Idle cycles (no up/down) leave count and flags unchanged.

Reset
REQ-029 reset asserted at a clock edge: count=0, empty_flag=1, almost_empty=1, full_flag=0, almost_full=(AF_LVL==0 ? n/a : 0), alarm=0, alarm_cause=0, err_cnt=0.
REQ-030 reset has priority over up_count, down_count and alarm_clr, including mid-operation at FULL with an alarm pending.
REQ-031 reset is sampled only on clk edges; asynchronous pulses between edges SHALL have no effect.

Configuration
REQ-032 Macro OCC_ALARM_LATCH_EN defined: alarm_cause bits are sticky until alarm_clr or reset (REQ-026/027 apply).
REQ-033 Macro OCC_ALARM_LATCH_EN undefined: alarm_cause reflects only the previous cycle's event (one-cycle pulse per event); alarm_clr ignored; err_cnt behaviour unchanged.

Verification
REQ-034 Default params, reset, 7 up_count pulses -> count 1..7, almost_full at count 6, full_flag=1 at 7, alarm=0.
REQ-035 At count 7, one more up_count -> count stays 7, alarm=1, alarm_cause=2'b10, err_cnt=1; with OCC_ALARM_LATCH_EN alarm holds until alarm_clr, without it drops after 1 cycle.
REQ-036 From reset, down_count -> count 0, empty_flag=1, alarm_cause=2'b01, err_cnt=1.
REQ-037 At count 0 and at count 7, up_count+down_count same cycle -> count unchanged, alarm=0, err_cnt unchanged.
REQ-038 260 back-to-back overflow events -> err_cnt saturates at 255; reset mid-stream -> all outputs at REQ-029 values on next edge.
REQ-039 CNT_W=5, CAP=20, AF_LVL=18, AE_LVL=2: fill to 20 and drain to 0 -> flag thresholds at 2/18/20/0 exactly, no wrap.
